xbit_sequencer: RTL and testbench
=================================

Name: xbit_sequencer

Overview:
- Multi-cycle sequencer for the CB-prefixed bit-operation group: rotate/shift, BIT, RES, SET on a register, on (HL), or on (IX+d)/(IY+d).
- Successor to the single-cycle register-only XBIT decoder.
  - Generalised register-file width (NUM_REGS).
  - Adds the memory read-modify-write sequence and the indexed addressing mode, with op and memory handshakes.
- Sits between the prefix decoder (XPT/XBIT state) and the register file / ALU / bus unit.

Parameters:
- REG_SEL_W, 3, width of the register select field in the opcode.
- NUM_REGS, 8, number of register-file write strobes; code (2^REG_SEL_W - 2) is the memory operand code.
- DATA_W, 8, width of the opcode and displacement bytes.

Ports:
- clk  in  1  system clock.
- notReset  in  1  asynchronous active-low reset.
- op_valid  in  1  opcode/displacement presented.
- op_ready  out  1  sequencer idle and able to accept.
- opcode  in  DATA_W  CB-group opcode byte.
- index_mode  in  2  0 = none, 1 = IX, 2 = IY, 3 = reserved.
- disp  in  DATA_W  signed displacement, used when index_mode != 0.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr_sel  out  2  0 = HL, 1 = IX+d, 2 = IY+d.
- mem_disp  out  DATA_W  latched displacement.
- mem_ack  in  1  bus transfer complete this cycle.
- alu_class  out  2  opcode[7:6]: 00 = rot/shift, 01 = BIT, 10 = RES, 11 = SET.
- alu_sub  out  3  opcode[5:3]: rotate kind or bit index.
- alu_en  out  1  ALU execute strobe.
- reg_write  out  NUM_REGS  one-hot register write strobe.
- sel_low  out  NUM_REGS  source register low-lane select.
- sel_high  out  NUM_REGS  source register high-lane select.
- invert_in  out  1  operand inversion for B, D, H, A.
- done  out  1  one-cycle completion pulse.
- err_mode  out  1  one-cycle pulse on reserved index_mode.

Behaviour:
- Reset (async, notReset = 0) forces state IDLE and all outputs 0 except op_ready = 1; latched opcode, disp and mode clear to 0.
- States: IDLE, REG_EX, MEM_RD, MEM_EX, MEM_WR, DONE.
- IDLE: op_ready = 1. On op_valid, latch opcode/index_mode/disp.
  - index_mode = 3: pulse err_mode, treat as 0.
  - index_mode = 0 and r != memory code → REG_EX.
  - Otherwise → MEM_RD.
- REG_EX, 1 cycle:
  - alu_en = 1.
  - sel_low[r] = ~opcode[7]; sel_high[r] = opcode[7].
  - reg_write[r] = 1 unless class = BIT.
  - → DONE.
- MEM_RD:
  - mem_req = 1, mem_we = 0, mem_addr_sel from mode (HL if mode 0).
  - Held until mem_ack, then → MEM_EX.
- MEM_EX, 1 cycle: alu_en = 1.
  - class = BIT → DONE.
  - Otherwise → MEM_WR.
- MEM_WR:
  - mem_req = 1, mem_we = 1, same address select.
  - Held until mem_ack, then → DONE.
- DONE: done = 1 for one cycle → IDLE. op_ready = 0 in every non-IDLE state.
- Latency with zero-wait acks:
  - Register form: done 2 cycles after acceptance.
  - Memory BIT: 3 + waits.
  - Memory RMW: 4 + waits.
- invert_in = 1 for r in {B = 0, D = 2, H = 4, A = 7}, otherwise 0; driven in REG_EX/MEM_EX.
- The memory code never asserts reg_write/sel_*.
- mem_ack outside MEM_RD/MEM_WR is ignored.
- op_valid while busy is not accepted and not buffered.
- Reset mid-sequence drops mem_req in the same instant; no done pulse.
- All strobe outputs are registered (decoded from state and latched fields), glitch-free.

Optional Feature:
- Macro XBIT_IDX_COPY_EN.
- Defined: for index_mode != 0 with r != memory code and class != BIT, MEM_WR also asserts reg_write[r] in its mem_ack cycle (undocumented copy-to-register).
- Undefined: indexed forms never assert reg_write; r is ignored except for the memory code.

Decomposition:
- Shared package xbit_pkg:
  - state enum.
  - alu_class constants (CLS_ROT, CLS_BIT, CLS_RES, CLS_SET).
  - index_mode constants.
  - function mem_code(REG_SEL_W).
- One natural sub-module: xbit_reg_onehot.
  - Combinational r-field to one-hot with enable.
  - Feeds reg_write, sel_low and sel_high.

Test Plan:
- opcode 0x00 (RLC B), mode 0, op_valid 1 cycle → next cycle reg_write = 0x01, sel_low = 0x01, invert_in = 1, alu_class = 0; done the cycle after.
- opcode 0x7E (BIT 7,(HL)), ack delayed 3 cycles:
  - mem_req held 4 cycles, mem_we = 0.
  - One alu_en cycle, no write, done; reg_write never set.
- opcode 0xC6 (SET 0,(HL)), zero-wait acks: read, alu_en, write with mem_we = 1, addr_sel = 0; done 4 cycles after accept.
- mode 2, disp 0xFE, opcode 0x8F (RES 1,A):
  - addr_sel = 2, mem_disp = 0xFE throughout.
  - reg_write[7] pulses in MEM_WR only with XBIT_IDX_COPY_EN; never without it.
- notReset asserted during MEM_WR → mem_req = 0 immediately, op_ready = 1, no done; index_mode = 3 → err_mode pulse, behaves as mode 0.

Source files
------------

// File: rtl/xbit_pkg.sv
// Shared types and helpers for the CB-group bit-operation sequencer.
package xbit_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REG_EX = 3'd1,
    MEM_RD = 3'd2,
    MEM_EX = 3'd3,
    MEM_WR = 3'd4,
    DONE   = 3'd5
  } xbit_state_e;

  localparam logic [1:0] CLS_ROT = 2'b00;
  localparam logic [1:0] CLS_BIT = 2'b01;
  localparam logic [1:0] CLS_RES = 2'b10;
  localparam logic [1:0] CLS_SET = 2'b11;

  localparam logic [1:0] IDX_NONE = 2'd0;
  localparam logic [1:0] IDX_IX   = 2'd1;
  localparam logic [1:0] IDX_IY   = 2'd2;
  localparam logic [1:0] IDX_RSVD = 2'd3;

  // Register-select code that stands for the (HL)/(IX+d)/(IY+d) operand.
  function automatic int mem_code(input int sel_w);
    return (1 << sel_w) - 2;
  endfunction

  // B, D, H and A sit on the inverted lane of the register file.
  function automatic logic invert_for(input int r);
    return (r == 0) || (r == 2) || (r == 4) || (r == 7);
  endfunction

endpackage

// File: rtl/xbit_sequencer_if.sv
// Op handshake, bus and register-file strobes of the bit-operation sequencer.
interface xbit_sequencer_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8
);
  logic                op_valid;
  logic                op_ready;
  logic [DATA_W-1:0]   opcode;
  logic [1:0]          index_mode;
  logic [DATA_W-1:0]   disp;
  logic                mem_req;
  logic                mem_we;
  logic [1:0]          mem_addr_sel;
  logic [DATA_W-1:0]   mem_disp;
  logic                mem_ack;
  logic [1:0]          alu_class;
  logic [2:0]          alu_sub;
  logic                alu_en;
  logic [NUM_REGS-1:0] reg_write;
  logic [NUM_REGS-1:0] sel_low;
  logic [NUM_REGS-1:0] sel_high;
  logic                invert_in;
  logic                done;
  logic                err_mode;

  modport slave (
    input  op_valid, opcode, index_mode, disp, mem_ack,
    output op_ready, mem_req, mem_we, mem_addr_sel, mem_disp,
           alu_class, alu_sub, alu_en, reg_write, sel_low, sel_high,
           invert_in, done, err_mode
  );

  modport master (
    output op_valid, opcode, index_mode, disp, mem_ack,
    input  op_ready, mem_req, mem_we, mem_addr_sel, mem_disp,
           alu_class, alu_sub, alu_en, reg_write, sel_low, sel_high,
           invert_in, done, err_mode
  );
endinterface

// File: rtl/xbit_reg_onehot.sv
// Register-select field to one-hot strobe vector, gated by an enable.
module xbit_reg_onehot #(
  parameter int SEL_W = 3,
  parameter int N     = 8
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [N-1:0]     onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < N; i++) begin
      if (en_i && (sel_i == SEL_W'(i))) onehot_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/xbit_sequencer.sv
// Multi-cycle sequencer for CB-prefixed rotate/shift, BIT, RES and SET.
// Build option: define XBIT_IDX_COPY_EN for the indexed copy-to-register write.
//
// state  | meaning
// IDLE   | op_ready high, waiting for op_valid
// REG_EX | register operand: ALU strobe plus register lane selects
// MEM_RD | operand read from memory, held until mem_ack
// MEM_EX | ALU strobe on the fetched operand
// MEM_WR | result written back, held until mem_ack
// DONE   | one-cycle completion pulse
module xbit_sequencer
  import xbit_pkg::*;
#(
  parameter int REG_SEL_W = 3,
  parameter int NUM_REGS  = 8,
  parameter int DATA_W    = 8
) (
  input logic         clk,
  input logic         notReset,
  xbit_sequencer_if.slave bus
);

  localparam logic [REG_SEL_W-1:0] MEM_CODE = REG_SEL_W'(mem_code(REG_SEL_W));

  xbit_state_e         state_q;
  logic [DATA_W-1:0]   opc_q;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   disp_q;
  logic                op_ready_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic                alu_en_q;
  logic [NUM_REGS-1:0] reg_write_q;
  logic [NUM_REGS-1:0] sel_low_q;
  logic [NUM_REGS-1:0] sel_high_q;
  logic                invert_q;
  logic                done_q;
  logic                err_q;

  logic                accept_d;
  logic [1:0]          mode_d;
  logic [REG_SEL_W-1:0] r_d;
  logic [1:0]          cls_d;
  logic                is_mem_d;
  logic [NUM_REGS-1:0] onehot_d;

  // Decode from the incoming byte on acceptance, otherwise from the latched one.
  assign accept_d = (state_q == IDLE) && bus.op_valid;
  assign mode_d   = (bus.index_mode == IDX_RSVD) ? IDX_NONE : bus.index_mode;
  assign r_d      = (state_q == IDLE) ? bus.opcode[REG_SEL_W-1:0] : opc_q[REG_SEL_W-1:0];
  assign cls_d    = (state_q == IDLE) ? bus.opcode[7:6] : opc_q[7:6];
  assign is_mem_d = (r_d == MEM_CODE);

  xbit_reg_onehot #(
    .SEL_W (REG_SEL_W),
    .N     (NUM_REGS)
  ) u_onehot (
    .sel_i    (r_d),
    .en_i     (!is_mem_d),
    .onehot_o (onehot_d)
  );

  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      state_q     <= IDLE;
      opc_q       <= '0;
      mode_q      <= '0;
      disp_q      <= '0;
      op_ready_q  <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      alu_en_q    <= 1'b0;
      reg_write_q <= '0;
      sel_low_q   <= '0;
      sel_high_q  <= '0;
      invert_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      alu_en_q    <= 1'b0;
      reg_write_q <= '0;
      sel_low_q   <= '0;
      sel_high_q  <= '0;
      invert_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            opc_q      <= bus.opcode;
            mode_q     <= mode_d;
            disp_q     <= bus.disp;
            err_q      <= (bus.index_mode == IDX_RSVD);
            op_ready_q <= 1'b0;
            if ((mode_d == IDX_NONE) && !is_mem_d) begin
              state_q  <= REG_EX;
              alu_en_q <= 1'b1;
              invert_q <= invert_for(int'(r_d));
              if (cls_d != CLS_BIT) reg_write_q <= onehot_d;
              if (bus.opcode[7]) sel_high_q <= onehot_d;
              else               sel_low_q  <= onehot_d;
            end else begin
              state_q   <= MEM_RD;
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b0;
            end
          end
        end
        REG_EX: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        MEM_RD: begin
          if (bus.mem_ack) begin
            state_q   <= MEM_EX;
            mem_req_q <= 1'b0;
            alu_en_q  <= 1'b1;
            invert_q  <= invert_for(int'(r_d));
          end
        end
        MEM_EX: begin
          if (cls_d == CLS_BIT) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q   <= MEM_WR;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b1;
`ifdef XBIT_IDX_COPY_EN
            if (mode_q != IDX_NONE) reg_write_q <= onehot_d;
`endif
          end
        end
        MEM_WR: begin
          if (bus.mem_ack) begin
            state_q   <= DONE;
            done_q    <= 1'b1;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end else begin
`ifdef XBIT_IDX_COPY_EN
            // Strobe is registered, so it is held across the whole write and covers the ack cycle.
            if (mode_q != IDX_NONE) reg_write_q <= onehot_d;
`endif
          end
        end
        DONE: begin
          state_q    <= IDLE;
          op_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= IDLE;
          op_ready_q <= 1'b1;
          mem_req_q  <= 1'b0;
          mem_we_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op_ready     = op_ready_q;
  assign bus.mem_req      = mem_req_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr_sel = mode_q;
  assign bus.mem_disp     = disp_q;
  assign bus.alu_class    = opc_q[7:6];
  assign bus.alu_sub      = opc_q[5:3];
  assign bus.alu_en       = alu_en_q;
  assign bus.reg_write    = reg_write_q;
  assign bus.sel_low      = sel_low_q;
  assign bus.sel_high     = sel_high_q;
  assign bus.invert_in    = invert_q;
  assign bus.done         = done_q;
  assign bus.err_mode     = err_q;

endmodule

// File: tb/tb_xbit_sequencer.sv
// Directed self-checking bench for xbit_sequencer.
module tb_xbit_sequencer;

  logic clk;
  logic notReset;
  int   checks;
  int   errors;
  logic [7:0] exp_copy;

  xbit_sequencer_if #(.DATA_W(8), .NUM_REGS(8)) bus ();

  xbit_sequencer #(
    .REG_SEL_W (3),
    .NUM_REGS  (8),
    .DATA_W    (8)
  ) dut (
    .clk      (clk),
    .notReset (notReset),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef XBIT_IDX_COPY_EN
    exp_copy = 8'h80;
`else
    exp_copy = 8'h00;
`endif
    notReset       = 1'b0;
    bus.op_valid   = 1'b0;
    bus.opcode     = 8'h00;
    bus.index_mode = 2'd0;
    bus.disp       = 8'h00;
    bus.mem_ack    = 1'b0;
    #12;
    chk("rst_op_ready", 32'(bus.op_ready), 32'd1);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_reg_write", 32'(bus.reg_write), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_mem_disp", 32'(bus.mem_disp), 32'd0);
    @(negedge clk);
    notReset = 1'b1;

    // RLC B
    bus.opcode = 8'h00; bus.op_valid = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    chk("rlcb_reg_write", 32'(bus.reg_write), 32'h01);
    chk("rlcb_sel_low", 32'(bus.sel_low), 32'h01);
    chk("rlcb_sel_high", 32'(bus.sel_high), 32'h00);
    chk("rlcb_invert", 32'(bus.invert_in), 32'd1);
    chk("rlcb_class", 32'(bus.alu_class), 32'd0);
    chk("rlcb_alu_en", 32'(bus.alu_en), 32'd1);
    chk("rlcb_op_ready", 32'(bus.op_ready), 32'd0);
    chk("rlcb_done_early", 32'(bus.done), 32'd0);
    tick();
    chk("rlcb_done", 32'(bus.done), 32'd1);
    chk("rlcb_reg_write_off", 32'(bus.reg_write), 32'h00);
    tick();
    chk("rlcb_idle_ready", 32'(bus.op_ready), 32'd1);
    chk("rlcb_done_off", 32'(bus.done), 32'd0);

    // RES 0,E: high lane, no inversion
    bus.opcode = 8'h83; bus.op_valid = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    chk("rese_reg_write", 32'(bus.reg_write), 32'h08);
    chk("rese_sel_high", 32'(bus.sel_high), 32'h08);
    chk("rese_sel_low", 32'(bus.sel_low), 32'h00);
    chk("rese_invert", 32'(bus.invert_in), 32'd0);
    chk("rese_class", 32'(bus.alu_class), 32'd2);
    tick(); tick();

    // BIT 0,A: no register write
    bus.opcode = 8'h47; bus.op_valid = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    chk("bita_reg_write", 32'(bus.reg_write), 32'h00);
    chk("bita_sel_low", 32'(bus.sel_low), 32'h80);
    chk("bita_invert", 32'(bus.invert_in), 32'd1);
    chk("bita_class", 32'(bus.alu_class), 32'd1);
    tick(); tick();

    // BIT 7,(HL) with a 3-cycle ack delay
    bus.opcode = 8'h7E; bus.op_valid = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bithl_mem_req", 32'(bus.mem_req), 32'd1);
      chk("bithl_mem_we", 32'(bus.mem_we), 32'd0);
      chk("bithl_alu_en_wait", 32'(bus.alu_en), 32'd0);
      chk("bithl_reg_write_rd", 32'(bus.reg_write), 32'h00);
      if (i == 3) bus.mem_ack = 1'b1;
      tick();
    end
    bus.mem_ack = 1'b0;
    chk("bithl_alu_en", 32'(bus.alu_en), 32'd1);
    chk("bithl_req_off", 32'(bus.mem_req), 32'd0);
    chk("bithl_reg_write_ex", 32'(bus.reg_write), 32'h00);
    chk("bithl_invert", 32'(bus.invert_in), 32'd0);
    tick();
    chk("bithl_done", 32'(bus.done), 32'd1);
    chk("bithl_no_wr", 32'(bus.mem_req), 32'd0);
    chk("bithl_alu_en_off", 32'(bus.alu_en), 32'd0);
    tick();
    chk("bithl_idle", 32'(bus.op_ready), 32'd1);

    // SET 0,(HL), zero-wait; op_valid while busy must be dropped
    bus.opcode = 8'hC6; bus.op_valid = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    bus.mem_ack = 1'b1;
    chk("sethl_rd_req", 32'(bus.mem_req), 32'd1);
    chk("sethl_rd_we", 32'(bus.mem_we), 32'd0);
    chk("sethl_addr", 32'(bus.mem_addr_sel), 32'd0);
    tick();
    bus.opcode = 8'h00; bus.op_valid = 1'b1;
    chk("sethl_alu_en", 32'(bus.alu_en), 32'd1);
    chk("sethl_ex_req", 32'(bus.mem_req), 32'd0);
    tick();
    chk("sethl_wr_req", 32'(bus.mem_req), 32'd1);
    chk("sethl_wr_we", 32'(bus.mem_we), 32'd1);
    chk("sethl_wr_addr", 32'(bus.mem_addr_sel), 32'd0);
    chk("sethl_wr_regw", 32'(bus.reg_write), 32'h00);
    chk("sethl_wr_ready", 32'(bus.op_ready), 32'd0);
    tick();
    bus.op_valid = 1'b0;
    bus.mem_ack = 1'b0;
    chk("sethl_done", 32'(bus.done), 32'd1);
    chk("sethl_done_req", 32'(bus.mem_req), 32'd0);
    tick();
    chk("sethl_idle", 32'(bus.op_ready), 32'd1);
    chk("sethl_not_relatched", 32'(bus.alu_class), 32'd3);
    chk("sethl_no_busy_accept", 32'(bus.alu_en), 32'd0);

    // RES 1,(IY-2) with r = A
    bus.opcode = 8'h8F; bus.index_mode = 2'd2; bus.disp = 8'hFE; bus.op_valid = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    bus.index_mode = 2'd0; bus.disp = 8'h00;
    bus.mem_ack = 1'b1;
    chk("resiy_rd_req", 32'(bus.mem_req), 32'd1);
    chk("resiy_rd_addr", 32'(bus.mem_addr_sel), 32'd2);
    chk("resiy_rd_disp", 32'(bus.mem_disp), 32'hFE);
    chk("resiy_rd_regw", 32'(bus.reg_write), 32'h00);
    tick();
    chk("resiy_ex_alu", 32'(bus.alu_en), 32'd1);
    chk("resiy_ex_invert", 32'(bus.invert_in), 32'd1);
    chk("resiy_ex_regw", 32'(bus.reg_write), 32'h00);
    tick();
    chk("resiy_wr_we", 32'(bus.mem_we), 32'd1);
    chk("resiy_wr_addr", 32'(bus.mem_addr_sel), 32'd2);
    chk("resiy_wr_disp", 32'(bus.mem_disp), 32'hFE);
    chk("resiy_wr_regw", 32'(bus.reg_write), 32'(exp_copy));
    chk("resiy_sub", 32'(bus.alu_sub), 32'd1);
    tick();
    bus.mem_ack = 1'b0;
    chk("resiy_done", 32'(bus.done), 32'd1);
    chk("resiy_done_regw", 32'(bus.reg_write), 32'h00);
    chk("resiy_done_disp", 32'(bus.mem_disp), 32'hFE);
    tick();

    // Reset in the middle of the write-back
    bus.opcode = 8'hC6; bus.op_valid = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    bus.mem_ack = 1'b0;
    tick();
    tick();
    tick();
    chk("rstmid_in_rd", 32'(bus.mem_we), 32'd0);
    bus.mem_ack = 1'b1;
    tick();
    tick();
    bus.mem_ack = 1'b0;
    chk("rstmid_in_wr", 32'(bus.mem_we), 32'd1);
    notReset = 1'b0;
    #1;
    chk("rstmid_req_drop", 32'(bus.mem_req), 32'd0);
    chk("rstmid_ready", 32'(bus.op_ready), 32'd1);
    chk("rstmid_class_clr", 32'(bus.alu_class), 32'd0);
    @(negedge clk);
    notReset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rstmid_no_done", 32'(bus.done), 32'd0);
      chk("rstmid_idle_req", 32'(bus.mem_req), 32'd0);
    end

    // Reserved index mode behaves as the plain register form
    bus.opcode = 8'h10; bus.index_mode = 2'd3; bus.op_valid = 1'b1;
    tick();
    bus.op_valid = 1'b0;
    bus.index_mode = 2'd0;
    chk("rsvd_err", 32'(bus.err_mode), 32'd1);
    chk("rsvd_alu_en", 32'(bus.alu_en), 32'd1);
    chk("rsvd_reg_write", 32'(bus.reg_write), 32'h01);
    chk("rsvd_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rsvd_addr", 32'(bus.mem_addr_sel), 32'd0);
    tick();
    chk("rsvd_err_pulse", 32'(bus.err_mode), 32'd0);
    chk("rsvd_done", 32'(bus.done), 32'd1);
    tick();
    chk("rsvd_idle", 32'(bus.op_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
